// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared constants and types for the FP16 comparator issue/collect slice.
//   FP16_W      : width of one FP16 operand
//   CMP_RES_W   : width of the comparator result word
//   CMP_LT_BIT  : result bit that reports A < B
//   fp16_pair_t : packed operand pair, A in the upper half, B in the lower
// ---------------------------------------------------------------------------
package fpu_pkg;

   localparam int FP16_W     = 16;
   localparam int CMP_RES_W  = 8;
   localparam int CMP_LT_BIT = 0;

   typedef struct packed {
      logic [FP16_W-1:0] a;
      logic [FP16_W-1:0] b;
   } fp16_pair_t;

   // Reinterpret a flat 32-bit stream word as an operand pair.
   function automatic fp16_pair_t unpack_pair(input logic [2*FP16_W-1:0] word);
      fp16_pair_t pair;
      pair = word;
      return pair;
   endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// ---------------------------------------------------------------------------
// fpu_sync_fifo
// Single-clock first-word fall-through FIFO. The head entry is always
// visible on pop_data while empty is low. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
// Ports:
//   aclk, areset        : clock, asynchronous active-high reset
//   push, push_data     : write request and data
//   pop                 : read request (ignored while empty)
//   pop_data            : head entry
//   full, empty, count  : occupancy status
// ---------------------------------------------------------------------------
module fpu_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full     = (count_r == CNT_W'(DEPTH));
   assign empty    = (count_r == {CNT_W{1'b0}});
   assign count    = count_r;
   assign pop_data = mem_r[rd_ptr_r];

   // Qualify requests against occupancy.
   always_comb begin
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
   end

   // Storage array; cleared on reset so the head reads zero while empty.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally at their power-of-two width.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy counter.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fpu_comp_issue.sv
// ---------------------------------------------------------------------------
// fpu_comp_issue
// Issues FP16 operand pairs to a valid-only comparator and collects its
// results in order into a FWFT buffer. A credit scheme (buffered results plus
// results still in flight never exceed DEPTH) guarantees room for every
// result, because the comparator cannot be stalled.
// Ports:
//   aclk, areset                 : clock, asynchronous active-high reset
//   s_axis_op_*                  : operand pair stream in (A=[31:16], B=[15:0])
//   m_axis_a_*, m_axis_b_*       : one-cycle issue pulse to the comparator
//   s_axis_cmp_*                 : comparator result (no backpressure)
//   m_axis_result_*              : buffered result stream out
//   err_overflow, err_spurious   : sticky error flags, cleared by reset only
// ---------------------------------------------------------------------------
module fpu_comp_issue
   import fpu_pkg::*;
#(
   parameter  int DEPTH   = 4,
   parameter  int LATENCY = 1,
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [2*FP16_W-1:0]  s_axis_op_tdata,
   input  logic                 s_axis_op_tvalid,
   output logic                 s_axis_op_tready,
   output logic [FP16_W-1:0]    m_axis_a_tdata,
   output logic                 m_axis_a_tvalid,
   output logic [FP16_W-1:0]    m_axis_b_tdata,
   output logic                 m_axis_b_tvalid,
   input  logic [CMP_RES_W-1:0] s_axis_cmp_tdata,
   input  logic                 s_axis_cmp_tvalid,
   output logic [CMP_RES_W-1:0] m_axis_result_tdata,
   output logic                 m_axis_result_tvalid,
   input  logic                 m_axis_result_tready,
   output logic                 err_overflow,
   output logic                 err_spurious
);

   fp16_pair_t           pair_s;
   logic                 op_fire_s;
   logic                 res_pop_s;
   logic                 push_s;
   logic                 dec_s;
   logic                 ovf_s;
   logic                 spur_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic [CNT_W-1:0]     fifo_count_s;
   logic [CNT_W-1:0]     fifo_count_nxt_s;
   logic [CNT_W-1:0]     inflight_nxt_s;
   logic [CNT_W:0]       credit_sum_s;
   logic                 ready_nxt_s;

   logic                 op_ready_r;
   logic [FP16_W-1:0]    a_r;
   logic [FP16_W-1:0]    b_r;
   logic                 issue_vld_r;
   logic [CNT_W-1:0]     inflight_r;
   logic                 ovf_r;
   logic                 spur_r;

   assign pair_s           = unpack_pair(s_axis_op_tdata);
   assign s_axis_op_tready = op_ready_r;
   assign m_axis_a_tdata   = a_r;
   assign m_axis_b_tdata   = b_r;
   assign m_axis_a_tvalid  = issue_vld_r;
   assign m_axis_b_tvalid  = issue_vld_r;
   assign m_axis_result_tvalid = ~fifo_empty_s;
   assign err_overflow     = ovf_r;
   assign err_spurious     = spur_r;

   // Handshake qualifiers for the operand and result streams.
   always_comb begin
      op_fire_s = s_axis_op_tvalid & op_ready_r;
      res_pop_s = ~fifo_empty_s & m_axis_result_tready;
   end

   // Result capture. A full buffer is only "full" if nothing leaves this edge;
   // the full check takes priority, and an overflowing result still consumes
   // its in-flight slot if there was one.
   always_comb begin
      push_s = 1'b0;
      dec_s  = 1'b0;
      ovf_s  = 1'b0;
      spur_s = 1'b0;
      if (s_axis_cmp_tvalid) begin
         if (fifo_full_s && !res_pop_s) begin
            ovf_s = 1'b1;
            dec_s = (inflight_r != {CNT_W{1'b0}});
         end else if (inflight_r == {CNT_W{1'b0}}) begin
            spur_s = 1'b1;
         end else begin
            push_s = 1'b1;
            dec_s  = 1'b1;
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // Next-state counts feed the registered credit decision.
   always_comb begin
      case ({op_fire_s, dec_s})
         2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
         2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
         default: inflight_nxt_s = inflight_r;
      endcase
      case ({push_s, res_pop_s})
         2'b10:   fifo_count_nxt_s = fifo_count_s + CNT_W'(1);
         2'b01:   fifo_count_nxt_s = fifo_count_s - CNT_W'(1);
         default: fifo_count_nxt_s = fifo_count_s;
      endcase
      credit_sum_s = {1'b0, fifo_count_nxt_s} + {1'b0, inflight_nxt_s};
      ready_nxt_s  = (credit_sum_s < (CNT_W+1)'(DEPTH));
   end

   // Issue registers: data held between accepts, valid is a single pulse.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         a_r         <= {FP16_W{1'b0}};
         b_r         <= {FP16_W{1'b0}};
         issue_vld_r <= 1'b0;
      end else begin
         issue_vld_r <= op_fire_s;
         if (op_fire_s) begin
            a_r <= pair_s.a;
            b_r <= pair_s.b;
         end
      end
   end

   // Credit state: in-flight counter and registered operand ready.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         inflight_r <= {CNT_W{1'b0}};
         op_ready_r <= 1'b0;
      end else begin
         inflight_r <= inflight_nxt_s;
         op_ready_r <= ready_nxt_s;
      end
   end

   // Sticky error flags.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ovf_r  <= 1'b0;
         spur_r <= 1'b0;
      end else begin
         ovf_r  <= ovf_r | ovf_s;
         spur_r <= spur_r | spur_s;
      end
   end

   fpu_sync_fifo #(
      .WIDTH (CMP_RES_W),
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .push      (push_s),
      .push_data (s_axis_cmp_tdata),
      .pop       (res_pop_s),
      .pop_data  (m_axis_result_tdata),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

endmodule

// File: tb/tb_fpu_comp_issue.sv
module tb_fpu_comp_issue;
   import fpu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int LATENCY = 1;

   logic        aclk;
   logic        areset;
   logic [31:0] op_tdata;
   logic        op_tvalid;
   logic        op_tready;
   logic [15:0] a_tdata;
   logic        a_tvalid;
   logic [15:0] b_tdata;
   logic        b_tvalid;
   logic [7:0]  cmp_tdata;
   logic        cmp_tvalid;
   logic [7:0]  res_tdata;
   logic        res_tvalid;
   logic        res_tready;
   logic        err_ovf;
   logic        err_spur;

   logic        inj;
   logic [7:0]  inj_data;

   int          n_cmp;
   int          n_bad;
   int          n_acc;
   int          n_pop;
   logic [7:0]  exp_cur;
   logic [7:0]  exp_q [$];

   fpu_comp_issue #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .aclk                 (aclk),
      .areset               (areset),
      .s_axis_op_tdata      (op_tdata),
      .s_axis_op_tvalid     (op_tvalid),
      .s_axis_op_tready     (op_tready),
      .m_axis_a_tdata       (a_tdata),
      .m_axis_a_tvalid      (a_tvalid),
      .m_axis_b_tdata       (b_tdata),
      .m_axis_b_tvalid      (b_tvalid),
      .s_axis_cmp_tdata     (cmp_tdata),
      .s_axis_cmp_tvalid    (cmp_tvalid),
      .m_axis_result_tdata  (res_tdata),
      .m_axis_result_tvalid (res_tvalid),
      .m_axis_result_tready (res_tready),
      .err_overflow         (err_ovf),
      .err_spurious         (err_spur)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Reference FP16 less-than: NaN and +0/-0 compare false.
   function automatic logic fp16_lt(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] ka;
      logic [15:0] kb;
      if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0))
         return 1'b0;
      if (a[14:0] == 15'd0 && b[14:0] == 15'd0)
         return 1'b0;
      ka = a[15] ? ~a : (a | 16'h8000);
      kb = b[15] ? ~b : (b | 16'h8000);
      return ka < kb;
   endfunction

   function automatic logic [7:0] cmp_word(input logic [15:0] a, input logic [15:0] b);
      logic [7:0] r;
      r = 8'h00;
      r[CMP_LT_BIT] = fp16_lt(a, b);
      return r;
   endfunction

   // Comparator stand-in with one edge of latency, no reset; inj forces a result.
   always @(posedge aclk) begin
      cmp_tvalid <= a_tvalid | inj;
      cmp_tdata  <= inj ? inj_data : cmp_word(a_tdata, b_tdata);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b);
      op_tdata  = {a, b};
      op_tvalid = 1'b1;
      exp_cur   = cmp_word(a, b);
   endtask

   // One clock: record handshakes seen before the edge, then settle after it.
   task automatic tick();
      logic [7:0] e;
      if (op_tvalid && op_tready) begin
         n_acc++;
         exp_q.push_back(exp_cur);
      end
      if (res_tvalid && res_tready) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            chk("res_extra", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("res_data", {24'd0, res_tdata}, {24'd0, e});
         end
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic drain(input int budget);
      op_tvalid  = 1'b0;
      res_tready = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (exp_q.size() == 0 && !res_tvalid) break;
         tick();
      end
      chk("drain_left", exp_q.size(), 32'd0);
   endtask

   logic [15:0] va [4];
   logic [15:0] vb [4];
   logic [7:0]  vr [4];
   logic [15:0] pa [6];
   logic [15:0] pb [6];

   initial begin
      int base;
      int pbase;
      int idx;
      logic [31:0] r;

      va[0] = 16'h3C00; vb[0] = 16'h4000; vr[0] = 8'h01;
      va[1] = 16'h4000; vb[1] = 16'h3C00; vr[1] = 8'h00;
      va[2] = 16'h3C00; vb[2] = 16'h3C00; vr[2] = 8'h00;
      va[3] = 16'hBC00; vb[3] = 16'h3C00; vr[3] = 8'h01;
      pa[0] = 16'h3C00; pb[0] = 16'h4000;
      pa[1] = 16'h4000; pb[1] = 16'h3C00;
      pa[2] = 16'hC000; pb[2] = 16'hBC00;
      pa[3] = 16'h0000; pb[3] = 16'h8000;
      pa[4] = 16'h3555; pb[4] = 16'h3556;
      pa[5] = 16'h7BFF; pb[5] = 16'hFBFF;

      n_cmp = 0; n_bad = 0; n_acc = 0; n_pop = 0;
      areset = 1'b1; op_tdata = 32'd0; op_tvalid = 1'b0; res_tready = 1'b0;
      inj = 1'b0; inj_data = 8'h00; exp_cur = 8'h00;

      // Reset state
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_op_tready", {31'd0, op_tready}, 32'd0);
      chk("rst_a_tvalid", {31'd0, a_tvalid}, 32'd0);
      chk("rst_res_tvalid", {31'd0, res_tvalid}, 32'd0);
      chk("rst_res_tdata", {24'd0, res_tdata}, 32'd0);
      chk("rst_flags", {30'd0, err_ovf, err_spur}, 32'd0);
      areset = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, op_tready}, 32'd1);

      // 1: single pairs, result visible 2 edges after accept
      for (int i = 0; i < 4; i++) begin
         drive(va[i], vb[i]);
         tick();
         op_tvalid = 1'b0;
         chk("t1_issue_a", {16'd0, a_tdata}, {16'd0, va[i]});
         chk("t1_issue_b", {16'd0, b_tdata}, {16'd0, vb[i]});
         chk("t1_issue_v", {30'd0, a_tvalid, b_tvalid}, 32'd3);
         tick();
         chk("t1_pulse", {31'd0, a_tvalid}, 32'd0);
         chk("t1_res_early", {31'd0, res_tvalid}, 32'd0);
         tick();
         chk("t1_res_v", {31'd0, res_tvalid}, 32'd1);
         chk("t1_res_d", {24'd0, res_tdata}, {24'd0, vr[i]});
         res_tready = 1'b1;
         tick();
         res_tready = 1'b0;
         chk("t1_empty", {31'd0, res_tvalid}, 32'd0);
      end

      // 2: streaming, one accept per cycle
      base = n_acc;
      res_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         r = $urandom();
         drive(r[31:16], r[15:0]);
         chk("t2_ready", {31'd0, op_tready}, 32'd1);
         tick();
      end
      drain(20);
      chk("t2_accepts", n_acc - base, 32'd16);

      // 3: backpressure limits accepts to DEPTH
      base = n_acc; pbase = n_pop;
      res_tready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         idx = n_acc - base;
         if (idx < 6) drive(pa[idx], pb[idx]);
         else op_tvalid = 1'b0;
         tick();
      end
      chk("t3_accepts4", n_acc - base, 32'd4);
      chk("t3_ready_low", {31'd0, op_tready}, 32'd0);
      chk("t3_res_v", {31'd0, res_tvalid}, 32'd1);
      res_tready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         idx = n_acc - base;
         if (idx >= 6 && exp_q.size() == 0) break;
         if (idx < 6) drive(pa[idx], pb[idx]);
         else op_tvalid = 1'b0;
         tick();
      end
      op_tvalid = 1'b0;
      chk("t3_accepts6", n_acc - base, 32'd6);
      chk("t3_pops6", n_pop - pbase, 32'd6);
      chk("t3_flags", {30'd0, err_ovf, err_spur}, 32'd0);

      // 4: result with nothing in flight
      res_tready = 1'b0;
      inj = 1'b1; inj_data = 8'h5A;
      tick();
      inj = 1'b0;
      tick();
      chk("t4_spurious", {31'd0, err_spur}, 32'd1);
      chk("t4_overflow", {31'd0, err_ovf}, 32'd0);
      chk("t4_fifo_empty", {31'd0, res_tvalid}, 32'd0);

      // 5: extra result into a full FIFO
      base = n_acc; pbase = n_pop;
      for (int c = 0; c < 10; c++) begin
         idx = n_acc - base;
         if (idx < 4) drive(pa[idx], pb[idx]);
         else op_tvalid = 1'b0;
         tick();
      end
      chk("t5_full_ready", {31'd0, op_tready}, 32'd0);
      inj = 1'b1; inj_data = 8'hA5;
      tick();
      inj = 1'b0;
      tick();
      chk("t5_overflow", {31'd0, err_ovf}, 32'd1);
      chk("t5_head", {24'd0, res_tdata}, {24'd0, exp_q[0]});
      drain(20);
      chk("t5_pops4", n_pop - pbase, 32'd4);

      // 6: reset with 3 buffered and 1 in flight
      res_tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(pa[i], pb[i]);
         tick();
      end
      op_tvalid = 1'b0;
      tick();
      chk("t6_cmp_inflight", {31'd0, cmp_tvalid}, 32'd1);
      areset = 1'b1;
      #1;
      chk("t6_rst_outs", {27'd0, op_tready, a_tvalid, b_tvalid, res_tvalid, err_ovf | err_spur}, 32'd0);
      chk("t6_rst_data", {res_tdata, a_tdata}, 32'd0);
      tick();
      tick();
      areset = 1'b0;
      exp_q.delete();
      tick();
      chk("t6_ready", {31'd0, op_tready}, 32'd1);
      chk("t6_empty", {31'd0, res_tvalid}, 32'd0);
      chk("t6_flags", {30'd0, err_ovf, err_spur}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
